// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared types and helpers for the AXI-Stream round-robin arbiter.
//   arb_state_t : arbiter FSM state (ARB = choosing a source, LOCK = packet in flight)
//   rr_pick     : round-robin selection starting just after the previous winner
package axis_arb_pkg;

  localparam int unsigned MAX_SRC   = 8;
  localparam int unsigned MAX_SRC_W = 3;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // First set bit of req scanning from last+1 upward, wrapping at n.
  // Returns last when nothing is requested (the caller only uses it when |req).
  function automatic logic [MAX_SRC_W-1:0] rr_pick(
    input logic [MAX_SRC-1:0]   req,
    input logic [MAX_SRC_W-1:0] last,
    input int unsigned          n = MAX_SRC
  );
    logic [MAX_SRC_W-1:0] pick;
    logic                 found;
    int unsigned          idx;
    pick  = last;
    found = 1'b0;
    for (int unsigned k = 1; k <= MAX_SRC; k++) begin
      if (k <= n && !found) begin
        idx = (int'(last) + k) % n;
        if (req[idx]) begin
          pick  = idx[MAX_SRC_W-1:0];
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: 2-entry register slice for a valid/ready stream.
// The downstream side is fully registered and the upstream ready is a pure
// register output, so no combinational path crosses the buffer. Sustains one
// transfer per cycle while dn_ready stays high.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   up_valid/up_ready   upstream handshake, up_data payload
//   dn_valid/dn_ready   downstream handshake, dn_data payload
module axis_skid_buffer
  import axis_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_data,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_data
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;

  // Upstream may push whenever the spare entry is empty.
  assign up_ready = !skid_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      dn_valid   <= 1'b0;
      dn_data    <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (dn_ready || !dn_valid) begin
      // Output register is free this cycle: drain the spare entry first.
      if (skid_valid) begin
        dn_valid   <= 1'b1;
        dn_data    <= skid_data;
        skid_valid <= 1'b0;
      end else begin
        dn_valid <= up_valid;
        if (up_valid) begin
          dn_data <= up_data;
        end
      end
    end else if (up_valid && !skid_valid) begin
      // Output stalled: park the beat accepted this cycle.
      skid_valid <= 1'b1;
      skid_data  <= up_data;
    end
  end

endmodule

// File: rtl/axis_rr_arbiter.sv
// axis_rr_arbiter: packet-granular round-robin arbiter sharing one AXI-Stream
// master between N_SRC sources. A grant lasts from the first beat to the TLAST
// beat; one ARB cycle separates packets. M_TID carries the granted index.
// Configuration macro: AXIS_ARB_OUTREG_EN -- when defined the master side goes
// through axis_skid_buffer (registered outputs, +1 cycle latency).
// Ports:
//   ACLK, ARESET                 clock, synchronous active-high reset
//   S_TVALID/S_TREADY            per-source handshake
//   S_TDATA/S_TKEEP/S_TUSER/S_TLAST  per-source payload, source i in slice i
//   M_TVALID/M_TREADY            master handshake
//   M_TDATA/M_TKEEP/M_TUSER/M_TID/M_TLAST  master payload
//   busy                         high while a grant is held (LOCK)
//   grant_idx                    current or most recent granted source
module axis_rr_arbiter
  import axis_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int USER_WIDTH = 3,
  parameter int N_SRC      = 4,
  parameter int SRC_W      = $clog2(N_SRC)
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [N_SRC-1:0]               S_TVALID,
  output logic [N_SRC-1:0]               S_TREADY,
  input  logic [N_SRC*DATA_WIDTH-1:0]    S_TDATA,
  input  logic [N_SRC*DATA_WIDTH/8-1:0]  S_TKEEP,
  input  logic [N_SRC*USER_WIDTH-1:0]    S_TUSER,
  input  logic [N_SRC-1:0]               S_TLAST,
  output logic                           M_TVALID,
  input  logic                           M_TREADY,
  output logic [DATA_WIDTH-1:0]          M_TDATA,
  output logic [DATA_WIDTH/8-1:0]        M_TKEEP,
  output logic [USER_WIDTH-1:0]          M_TUSER,
  output logic [SRC_W-1:0]               M_TID,
  output logic                           M_TLAST,
  output logic                           busy,
  output logic [SRC_W-1:0]               grant_idx
);

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int PAY_W  = DATA_WIDTH + KEEP_W + USER_WIDTH + SRC_W + 1;

  arb_state_t               state, state_nxt;
  logic [SRC_W-1:0]         grant_nxt;
  logic [SRC_W-1:0]         last_grant, last_nxt;

  logic                     sel_valid;
  logic                     sel_ready;
  logic [DATA_WIDTH-1:0]    sel_data;
  logic [KEEP_W-1:0]        sel_keep;
  logic [USER_WIDTH-1:0]    sel_user;
  logic [SRC_W-1:0]         sel_tid;
  logic                     sel_last;

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= ARB;
      grant_idx  <= '0;
      last_grant <= SRC_W'(N_SRC - 1);
    end else begin
      state      <= state_nxt;
      grant_idx  <= grant_nxt;
      last_grant <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_idx;
    last_nxt  = last_grant;
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    sel_user  = '0;
    sel_tid   = '0;
    sel_last  = 1'b0;
    S_TREADY  = '0;
    case (state)
      ARB: begin
        if (|S_TVALID) begin
          grant_nxt = SRC_W'(rr_pick(MAX_SRC'(S_TVALID), MAX_SRC_W'(last_grant), N_SRC));
          state_nxt = LOCK;
        end
      end
      LOCK: begin
        sel_valid = S_TVALID[grant_idx];
        sel_data  = S_TDATA[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = S_TKEEP[int'(grant_idx)*KEEP_W +: KEEP_W];
        sel_user  = S_TUSER[int'(grant_idx)*USER_WIDTH +: USER_WIDTH];
        sel_last  = S_TLAST[grant_idx];
        sel_tid   = grant_idx;
        S_TREADY[grant_idx] = sel_ready;
        if (sel_valid && sel_ready && sel_last) begin
          last_nxt  = grant_idx;
          state_nxt = ARB;
        end
      end
    endcase
  end

  assign busy = (state == LOCK);

`ifdef AXIS_ARB_OUTREG_EN
  logic [PAY_W-1:0] up_pay;
  logic [PAY_W-1:0] dn_pay;

  // The grant is released once TLAST enters the buffer, not when it leaves.
  assign up_pay = {sel_data, sel_keep, sel_user, sel_tid, sel_last};

  axis_skid_buffer #(
    .WIDTH (PAY_W)
  ) u_skid (
    .clk      (ACLK),
    .rst      (ARESET),
    .up_valid (sel_valid),
    .up_ready (sel_ready),
    .up_data  (up_pay),
    .dn_valid (M_TVALID),
    .dn_ready (M_TREADY),
    .dn_data  (dn_pay)
  );

  assign {M_TDATA, M_TKEEP, M_TUSER, M_TID, M_TLAST} = dn_pay;
`else
  assign sel_ready = M_TREADY;
  assign M_TVALID  = sel_valid;
  assign M_TDATA   = sel_data;
  assign M_TKEEP   = sel_keep;
  assign M_TUSER   = sel_user;
  assign M_TID     = sel_tid;
  assign M_TLAST   = sel_last;
`endif

endmodule
